// File: rtl/date_time_display.sv
// Date/time page display for six active-low 7-segment digits.
// Rotates TIME/DATE/YEAR pages on a dwell timer or a button press.
module date_time_display #(
    parameter int PAGE_TICKS = 150
) (
    input  logic        MAX10_CLK1_50,
    input  logic        KEY,
    input  logic        i_next,
    input  logic [11:0] i_year,
    input  logic [3:0]  i_month,
    input  logic [7:0]  i_day,
    input  logic [7:0]  i_hour,
    input  logic [7:0]  i_min,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5
);

    localparam int CW = (PAGE_TICKS > 1) ? $clog2(PAGE_TICKS) : 1;

    typedef enum logic [1:0] {
        PG_TIME,
        PG_DATE,
        PG_YEAR
    } page_e;

    typedef enum logic {
        CV_LOAD,
        CV_SHIFT
    } cv_e;

    logic clk;
    logic rst_n;
    assign clk   = MAX10_CLK1_50;
    assign rst_n = KEY;

    page_e   page_q, page_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic    sync1_q, sync2_q, sync3_q;
    logic    fall, expire, adv;

    cv_e         cv_q, cv_d;
    logic [11:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  sh_q, sh_d;
    logic [15:0] year_q, year_d;
    logic [15:0] adj;
    logic [15:0] shifted;

    logic [7:0] hex_q [6];
    logic [7:0] hex_d [6];

    logic       mon_t;
    logic [3:0] mon_u;

    // Button synchronizer plus one delay flop for falling-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            sync3_q <= 1'b1;
        end else begin
            sync1_q <= i_next;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign fall   = sync3_q & ~sync2_q;
    assign expire = (cnt_q == CW'(PAGE_TICKS - 1));
    assign adv    = fall | expire;

    // Page and dwell counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q <= PG_TIME;
            cnt_q  <= '0;
        end else begin
            page_q <= page_d;
            cnt_q  <= cnt_d;
        end
    end

    // A press and a dwell expiry together still advance a single step
    always_comb begin
        page_d = page_q;
        cnt_d  = cnt_q + 1'b1;
        if (adv) begin
            cnt_d = '0;
            case (page_q)
                PG_TIME: page_d = PG_DATE;
                PG_DATE: page_d = PG_YEAR;
                default: page_d = PG_TIME;
            endcase
        end
    end

    // Year converter state and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q   <= CV_LOAD;
            bin_q  <= '0;
            bcd_q  <= '0;
            sh_q   <= '0;
            year_q <= '0;
        end else begin
            cv_q   <= cv_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            sh_q   <= sh_d;
            year_q <= year_d;
        end
    end

    // Free-running double-dabble: load, then 12 add-3/shift steps
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {adj[14:0], bin_q[11]};

        cv_d   = cv_q;
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        sh_d   = sh_q;
        year_d = year_q;
        case (cv_q)
            CV_LOAD: begin
                bin_d = i_year;
                bcd_d = '0;
                sh_d  = '0;
                cv_d  = CV_SHIFT;
            end
            default: begin
                bin_d = {bin_q[10:0], 1'b0};
                bcd_d = shifted;
                sh_d  = sh_q + 4'd1;
                if (sh_q == 4'd11) begin
                    year_d = shifted;
                    cv_d   = CV_LOAD;
                end
            end
        endcase
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] digit(input logic [3:0] d,
                                         input logic dp);
        return {~dp, seg7(d)};
    endfunction

    assign mon_t = (i_month >= 4'd10);
    assign mon_u = mon_t ? (i_month - 4'd10) : i_month;

    // Select the four digits and decimal point for the current page
    always_comb begin
        hex_d[5] = 8'hFF;
        hex_d[4] = 8'hFF;
        hex_d[3] = 8'hFF;
        hex_d[2] = 8'hFF;
        hex_d[1] = 8'hFF;
        hex_d[0] = 8'hFF;
        case (page_q)
            PG_TIME: begin
                hex_d[3] = digit(i_hour[7:4], 1'b0);
                hex_d[2] = digit(i_hour[3:0], 1'b1);
                hex_d[1] = digit(i_min[7:4], 1'b0);
                hex_d[0] = digit(i_min[3:0], 1'b0);
            end
            PG_DATE: begin
                hex_d[3] = digit(i_day[7:4], 1'b0);
                hex_d[2] = digit(i_day[3:0], 1'b1);
                hex_d[1] = digit({3'b000, mon_t}, 1'b0);
                hex_d[0] = digit(mon_u, 1'b0);
            end
            default: begin
                hex_d[3] = digit(year_q[15:12], 1'b0);
                hex_d[2] = digit(year_q[11:8], 1'b0);
                hex_d[1] = digit(year_q[7:4], 1'b0);
                hex_d[0] = digit(year_q[3:0], 1'b0);
            end
        endcase
    end

    // Registered segment outputs, blank while in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= 8'hFF;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                hex_q[i] <= hex_d[i];
            end
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_date_time_display.sv
// Directed bench for date_time_display with a queue scoreboard.
// Expected 48-bit words are {HEX5..HEX0}.
module tb_date_time_display;

    logic        clk;
    logic        key;
    logic        nxt;
    logic [11:0] year;
    logic [3:0]  month;
    logic [7:0]  day, hour, minute;
    logic [7:0]  h0, h1, h2, h3, h4, h5;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [47:0] exp;
    } exp_t;

    exp_t sb[$];

    localparam logic [47:0] ALL_FF   = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] T_2359   = 48'hFFFF_A430_9290;
    localparam logic [47:0] D_3112   = 48'hFFFF_B079_F9A4;
    localparam logic [47:0] D_3100   = 48'hFFFF_B079_C0C0;
    localparam logic [47:0] Y_2024   = 48'hFFFF_A4C0_A499;
    localparam logic [47:0] Y_4095   = 48'hFFFF_99C0_9092;
    localparam logic [47:0] Y_0000   = 48'hFFFF_C0C0_C0C0;
    localparam logic [47:0] T_DASH   = 48'hFFFF_A43F_92BF;

    date_time_display #(.PAGE_TICKS(150)) dut (
        .MAX10_CLK1_50 (clk),
        .KEY           (key),
        .i_next        (nxt),
        .i_year        (year),
        .i_month       (month),
        .i_day         (day),
        .i_hour        (hour),
        .i_min         (minute),
        .HEX0          (h0),
        .HEX1          (h1),
        .HEX2          (h2),
        .HEX3          (h3),
        .HEX4          (h4),
        .HEX5          (h5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [47:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t        e;
        logic [47:0] obs;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty");
        end else begin
            e   = sb.pop_front();
            obs = {h5, h4, h3, h2, h1, h0};
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed %h expected %h",
                       e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic exp_chk(input string tag, input logic [47:0] v);
        expect_out(tag, v);
        check_out();
    endtask

    task automatic do_reset();
        key = 1'b0;
        step(2);
        exp_chk("reset_blank", ALL_FF);
        key = 1'b1;
    endtask

    initial begin
        key    = 1'b1;
        nxt    = 1'b1;
        year   = 12'd2024;
        month  = 4'd12;
        day    = 8'h31;
        hour   = 8'h23;
        minute = 8'h59;
        #3;
        key = 1'b0;

        // Power-on reset, then TIME page on first edge
        do_reset();
        step(1);
        exp_chk("time_2359", T_2359);

        // Button press to DATE, then month zero
        nxt = 1'b0;
        step(4);
        exp_chk("date_3112", D_3112);
        nxt = 1'b1;
        step(3);
        month = 4'd0;
        step(1);
        exp_chk("date_month0", D_3100);
        month = 4'd12;
        step(10);

        // Press to YEAR page, then change year
        nxt = 1'b0;
        step(4);
        exp_chk("year_2024", Y_2024);
        nxt = 1'b1;
        step(3);
        year = 12'd4095;
        step(26);
        exp_chk("year_4095", Y_4095);

        // Held button advances only once: YEAR -> TIME
        nxt = 1'b0;
        step(20);
        exp_chk("held_once", T_2359);
        nxt = 1'b1;
        step(3);

        // Out-of-range BCD shows dashes
        hour   = 8'h2A;
        minute = 8'h5F;
        step(1);
        exp_chk("dash", T_DASH);
        hour   = 8'h23;
        minute = 8'h59;
        step(1);

        // Reset mid-conversion, then auto-rotation timing
        do_reset();
        step(1);
        exp_chk("rot_t_e1", T_2359);
        step(148);
        exp_chk("rot_t_e149", T_2359);
        step(2);
        exp_chk("rot_d_e151", D_3112);
        step(149);
        exp_chk("rot_d_e300", D_3112);
        step(1);
        exp_chk("rot_y_e301", Y_4095);
        step(150);
        exp_chk("rot_t_e451", T_2359);

        // Button edge coincident with dwell expiry
        do_reset();
        step(147);
        nxt = 1'b0;
        step(4);
        exp_chk("coinc_single", D_3112);
        step(149);
        exp_chk("coinc_d_e300", D_3112);
        step(1);
        exp_chk("coinc_y_e301", Y_4095);
        nxt = 1'b1;
        step(3);

        // Year register cleared by reset, reconverted afterwards
        year = 12'd2024;
        do_reset();
        nxt = 1'b0;
        step(4);
        exp_chk("rst_date", D_3112);
        nxt = 1'b1;
        step(3);
        nxt = 1'b0;
        step(4);
        exp_chk("rst_year_zero", Y_0000);
        nxt = 1'b1;
        step(3);
        step(12);
        exp_chk("rst_year_2024", Y_2024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/date_time_display.md
DATE_TIME_DISPLAY -- requirements
Module: date_time_display

Interface
REQ-001 Parameter PAGE_TICKS, default 150: clock cycles each display page is held in auto-rotate.
REQ-002 MAX10_CLK1_50  in  1  system clock; all state changes on its rising edge.
REQ-003 KEY  in  1  reset; asynchronous, active-low.
REQ-004 i_next  in  1  page-advance button; active-low; asynchronous to logic.
REQ-005 i_year  in  12  binary year, 0..4095.
REQ-006 i_month  in  4  binary month, 0..15.
REQ-007 i_day  in  8  BCD day, {tens, units}.
REQ-008 i_hour  in  8  BCD hour, {tens, units}.
REQ-009 i_min  in  8  BCD minute, {tens, units}.
REQ-010 HEX0..HEX5  out  8 each  active-low 7-segment outputs; bit0=a .. bit6=g, bit7=dp; HEX0 rightmost.

Function
REQ-011 Page FSM SHALL have states TIME, DATE, YEAR, advancing TIME->DATE->YEAR->TIME.
REQ-012 Dwell counter SHALL count 0..PAGE_TICKS-1; at PAGE_TICKS-1 it SHALL wrap to 0 and advance the page.
REQ-013 i_next SHALL pass a 2-flop synchronizer; a synchronized high-to-low edge SHALL advance the page one step and clear the dwell counter.
REQ-014 Edge and dwell expiry in the same cycle SHALL advance the page exactly one step.
REQ-015 A held-low i_next SHALL produce only one advance.
REQ-016 Year SHALL convert binary-to-BCD by sequential shift-add-3: one load cycle plus 12 shift cycles, free-running.
REQ-017 A completed conversion SHALL latch 4 BCD digits into a year register; displayed year SHALL reflect a new i_year within 26 cycles.
REQ-018 Month SHALL convert combinationally: tens = (i_month >= 10), units = i_month - 10*tens.
REQ-019 TIME page: HEX3/HEX2 = hour tens/units, HEX1/HEX0 = minute tens/units, dp lit on HEX2, HEX5/HEX4 blank.
REQ-020 DATE page: HEX3/HEX2 = day tens/units, HEX1/HEX0 = month tens/units, dp lit on HEX2, HEX5/HEX4 blank.
REQ-021 YEAR page: HEX3..HEX0 = year thousands..units, no dp, HEX5/HEX4 blank.
REQ-022 Digit encoding: 0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90 (hex); blank=FF; lit dp clears bit7.
REQ-023 Any BCD nibble > 9 SHALL display dash (BF, bit7 per page rule).
REQ-024 All HEX outputs SHALL be registered: 1-cycle latency from page change or input change (year: per REQ-017).

Reset
REQ-025 KEY low SHALL immediately force page=TIME, dwell counter=0, synchronizer flops=1, year register=0000, converter to load state, all HEX=FF.
REQ-026 Reset asserted mid-conversion SHALL discard the partial result; conversion SHALL restart from load after release.
REQ-027 On the first clock edge after KEY rises, outputs SHALL show the TIME page.

Verification
REQ-028 TIME page, i_hour=23h, i_min=59h -> HEX3=A4, HEX2=30, HEX1=92, HEX0=90, HEX5=HEX4=FF.
REQ-029 i_year=2024, YEAR page, wait 26 cycles -> HEX3=A4, HEX2=C0, HEX1=A4, HEX0=99; then i_year=4095 -> within 26 cycles HEX3..HEX0=99,C0,90,92.
REQ-030 DATE page, i_day=31h, month 12 then 0 -> HEX3=B0, HEX2=79, HEX1=F9, HEX0=A4; then HEX1=HEX0=C0.
REQ-031 No button, PAGE_TICKS=150 -> page changes every 150 cycles TIME->DATE->YEAR->TIME; i_next falling edge on the same cycle as expiry -> single advance, dwell restarts at 0.
REQ-032 i_hour=2Ah -> HEX2=3F (dash with dp); KEY pulsed low during conversion -> HEX all FF while low, TIME page and correct year within 26 cycles after release.
